// File: rtl/sudoku_pkg.sv
// Shared types and width helpers for the sudoku board datapath.
package sudoku_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPlay,
        StCheck,
        StWon,
        StLost
    } state_e;

    localparam int unsigned PkgBox   = 2;
    localparam int unsigned PkgN     = PkgBox * PkgBox;
    localparam int unsigned PkgCells = PkgN * PkgN;

    function automatic int unsigned calc_n(input int unsigned box);
        return box * box;
    endfunction

    function automatic int unsigned calc_cells(input int unsigned box);
        return (box * box) * (box * box);
    endfunction

    // Value width: must hold 0 (empty) through N.
    function automatic int unsigned calc_vw(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned calc_iw(input int unsigned cells);
        return (cells < 2) ? 1 : $clog2(cells);
    endfunction

    // Counter width for a down-counter starting at m; never narrower than one bit.
    function automatic int unsigned calc_cw(input int unsigned m);
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sudoku_checker.sv
// Serial solution checker: scans one cell per cycle and flags any user/solution mismatch.
module sudoku_checker #(
    parameter int unsigned Cells = 16,
    parameter int unsigned Iw    = 4,
    parameter int unsigned Vw    = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    output logic [Iw-1:0] scan_idx_o,
    input  logic [Vw-1:0] sol_val_i,
    input  logic [Vw-1:0] usr_val_i,
    output logic          last_o,
    output logic          mismatch_o,
    output logic          done_o
);

    localparam int unsigned   Cw      = $clog2(Cells + 1);
    localparam logic [Iw-1:0] LastIdx = Iw'(Cells - 1);

    logic          active_q, active_d;
    logic [Iw-1:0] idx_q, idx_d;
    logic [Cw-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          cur_mis;

    // An empty user cell is always wrong, even against an unloaded solution cell.
    assign cur_mis    = active_q && ((usr_val_i != sol_val_i) || (usr_val_i == '0));
    assign last_o     = active_q && (idx_q == LastIdx);
    // Includes the cell under scan so the verdict is ready on the final scan cycle.
    assign mismatch_o = (cnt_q != '0) || cur_mis;
    assign scan_idx_o = idx_q;
    assign done_o     = done_q;

    always_comb begin
        active_d = active_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        done_d   = last_o;
        if (start_i) begin
            active_d = 1'b1;
            idx_d    = '0;
            cnt_d    = '0;
        end else if (active_q) begin
            cnt_d = cnt_q + Cw'(cur_mis);
            if (last_o) begin
                active_d = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: rtl/sudoku_board_dp.sv
// Sudoku board datapath: solution/given/user storage, game FSM and write/hint arbitration.
// Hint reveal is built only when SUDOKU_HINT_EN is defined; otherwise hints_left reads 0.
module sudoku_board_dp
    import sudoku_pkg::*;
#(
    parameter int unsigned  BOX       = 2,
    parameter int unsigned  MAX_TRIES = 3,
    parameter int unsigned  HINTS     = 2,
    localparam int unsigned N         = calc_n(BOX),
    localparam int unsigned CELLS     = calc_cells(BOX),
    localparam int unsigned VW        = calc_vw(N),
    localparam int unsigned IW        = calc_iw(CELLS),
    localparam int unsigned TW        = calc_cw(MAX_TRIES),
    localparam int unsigned HW        = calc_cw(HINTS)
) (
    input  logic             clka,
    input  logic             restart,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [IW-1:0]    load_idx,
    input  logic [VW-1:0]    load_val,
    input  logic             load_given,
    input  logic             load_last,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [VW-1:0]    wr_val,
    output logic             wr_err,
    input  logic             check_req,
    input  logic             try_again,
    input  logic             hint_req,
    input  logic [IW-1:0]    hint_idx,
    output logic [HW-1:0]    hints_left,
    input  logic [IW-1:0]    rd_idx,
    output logic [VW-1:0]    rd_user,
    output logic             rd_given,
    output logic [CELLS-1:0] fill_flag,
    output logic             busy,
    output logic             check_done,
    output logic             solved,
    output logic             game_over,
    output logic [TW-1:0]    tries_left
);

    localparam logic [IW:0]   CellsX   = CELLS[IW:0];
    localparam logic [VW-1:0] MaxVal   = VW'(N);
    localparam logic [TW-1:0] TriesRst = TW'(MAX_TRIES);

    state_e        state_q, state_d;
    logic [VW-1:0] sol_q [CELLS];
    logic [VW-1:0] sol_d [CELLS];
    logic [VW-1:0] usr_q [CELLS];
    logic [VW-1:0] usr_d [CELLS];
    logic          giv_q [CELLS];
    logic          giv_d [CELLS];
    logic [TW-1:0] tries_q, tries_d;
    logic          wr_err_q, wr_err_d;

    logic          load_fire;
    logic          load_in_rng, wr_in_rng, rd_in_rng;
    logic          wr_ok;
    logic          hint_take;
    logic          chk_start, chk_last, chk_mis, chk_done;
    logic [IW-1:0] chk_idx;
    logic [VW-1:0] chk_sol, chk_usr;

    assign load_ready  = (state_q == StIdle) || (state_q == StLoad);
    assign load_fire   = load_valid && load_ready;
    assign load_in_rng = {1'b0, load_idx} < CellsX;
    assign wr_in_rng   = {1'b0, wr_idx} < CellsX;
    assign rd_in_rng   = {1'b0, rd_idx} < CellsX;
    assign wr_ok       = wr_in_rng && !giv_q[wr_idx] && (wr_val <= MaxVal);

`ifdef SUDOKU_HINT_EN
    logic [HW-1:0] hints_q, hints_d;
    logic          hint_ok;

    assign hint_ok    = ({1'b0, hint_idx} < CellsX) && !giv_q[hint_idx] && (hints_q != '0);
    assign hint_take  = (state_q == StPlay) && hint_req && hint_ok;
    assign hints_left = hints_q;

    always_comb begin
        hints_d = hints_q;
        if (hint_take) begin
            hints_d = hints_q - 1'b1;
        end
    end

    // Hints survive try_again; only restart refills them.
    always_ff @(posedge clka) begin
        if (restart) begin
            hints_q <= HW'(HINTS);
        end else begin
            hints_q <= hints_d;
        end
    end
`else
    logic unused_hint;

    assign unused_hint = ^{hint_req, hint_idx};
    assign hint_take   = 1'b0;
    assign hints_left  = '0;
`endif

    always_comb begin
        state_d   = state_q;
        sol_d     = sol_q;
        giv_d     = giv_q;
        usr_d     = usr_q;
        tries_d   = tries_q;
        wr_err_d  = 1'b0;
        chk_start = 1'b0;
        unique case (state_q)
            StIdle, StLoad: begin
                wr_err_d = wr_en;
                if (load_fire) begin
                    if (load_in_rng) begin
                        sol_d[load_idx] = load_val;
                        giv_d[load_idx] = load_given;
                        usr_d[load_idx] = load_given ? load_val : '0;
                    end
                    state_d = load_last ? StPlay : StLoad;
                end
            end
            StPlay: begin
                if (hint_take) begin
                    usr_d[hint_idx] = sol_q[hint_idx];
                    giv_d[hint_idx] = 1'b1;
                end
                // A hint to the same cell outranks the user write.
                if (wr_en) begin
                    if (wr_ok && !(hint_take && (wr_idx == hint_idx))) begin
                        usr_d[wr_idx] = wr_val;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end
                if (check_req) begin
                    state_d   = StCheck;
                    chk_start = 1'b1;
                end
            end
            StCheck: begin
`ifdef SUDOKU_HINT_EN
                wr_err_d = wr_en || hint_req;
`else
                wr_err_d = wr_en;
`endif
                if (chk_last) begin
                    if (!chk_mis) begin
                        state_d = StWon;
                    end else begin
                        tries_d = tries_q - 1'b1;
                        state_d = (tries_q == TW'(1)) ? StLost : StPlay;
                    end
                end
            end
            StWon: begin
                wr_err_d = wr_en;
            end
            StLost: begin
                wr_err_d = wr_en;
                if (try_again) begin
                    for (int i = 0; i < CELLS; i++) begin
                        if (!giv_q[i]) begin
                            usr_d[i] = '0;
                        end
                    end
                    tries_d = TriesRst;
                    state_d = StPlay;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            state_q  <= StIdle;
            sol_q    <= '{default: '0};
            usr_q    <= '{default: '0};
            giv_q    <= '{default: 1'b0};
            tries_q  <= TriesRst;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sol_q    <= sol_d;
            usr_q    <= usr_d;
            giv_q    <= giv_d;
            tries_q  <= tries_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign chk_sol = sol_q[chk_idx];
    assign chk_usr = usr_q[chk_idx];

    sudoku_checker #(
        .Cells (CELLS),
        .Iw    (IW),
        .Vw    (VW)
    ) u_checker (
        .clk_i      (clka),
        .rst_i      (restart),
        .start_i    (chk_start),
        .scan_idx_o (chk_idx),
        .sol_val_i  (chk_sol),
        .usr_val_i  (chk_usr),
        .last_o     (chk_last),
        .mismatch_o (chk_mis),
        .done_o     (chk_done)
    );

    always_comb begin
        fill_flag = '0;
        for (int i = 0; i < CELLS; i++) begin
            fill_flag[i] = (usr_q[i] != '0);
        end
    end

    assign rd_user    = rd_in_rng ? usr_q[rd_idx] : '0;
    assign rd_given   = rd_in_rng ? giv_q[rd_idx] : 1'b0;
    assign wr_err     = wr_err_q;
    assign busy       = (state_q == StLoad) || (state_q == StCheck);
    assign check_done = chk_done;
    assign solved     = (state_q == StWon);
    assign game_over  = (state_q == StLost);
    assign tries_left = tries_q;

endmodule
